// File: rtl/dll_tx_tlp_framer.sv
// Data-link-layer transmit framer: tags each TLP with a sequence number and LCRC, keeps it in a
// replay buffer until ACKed, and replays outstanding entries oldest-first after a NAK.
module dll_tx_tlp_framer #(
  parameter int unsigned REPLAY_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1151:0] tlp_i,
  input  logic          tlp_valid_i,
  output logic          tlp_ready_o,
  output logic [1195:0] dll_tlp_o,
  output logic          dll_tlp_valid_o,
  input  logic          dll_tlp_ready_i,
  input  logic          ack_valid_i,
  input  logic [11:0]   ack_seq_i,
  input  logic          nak_valid_i,
  input  logic [11:0]   nak_seq_i,
  output logic [11:0]   next_seq_o,
  output logic          replay_busy_o
);

  localparam int unsigned AW = (REPLAY_DEPTH > 1) ? $clog2(REPLAY_DEPTH) : 1;
  localparam int unsigned OW = AW + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StSend, StReplay} state_e;

  state_e          state_q;
  logic [1151:0]   tlp_q;
  logic [11:0]     next_seq_q;
  logic [OW-1:0]   occ_q;
  logic            pending_q;
  logic [1195:0]   out_q;
  logic            out_valid_q;
  logic [1195:0]   mem [REPLAY_DEPTH];

  logic [11:0]     occ_ext, oldest_seq, purge_seq, purge_dist, purge_cnt, oldest_new;
  logic [11:0]     cur_seq, cand_seq;
  logic            purge_hit, occ_d_nz, pend_any, cand_live, last_beat;
  logic [OW-1:0]   occ_d;
  logic [AW-1:0]   rd_idx, wr_idx;
  logic [31:0]     lcrc;
  logic [1195:0]   new_word, rd_word;

  // CRC-32, polynomial 04C11DB7, seeded with all ones, MSB of the TLP first, no reflection.
  function automatic logic [31:0] crc32(input logic [1151:0] d);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 1151; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
    end
    return c;
  endfunction

  // Entry with sequence s always lives at slot s mod depth, so pointers fall out of the seqs.
  always_comb begin
    occ_ext    = 12'(occ_q);
    oldest_seq = next_seq_q - occ_ext;
    purge_seq  = nak_valid_i ? nak_seq_i : ack_seq_i;
    purge_dist = purge_seq - oldest_seq;
    purge_hit  = (nak_valid_i | ack_valid_i) && (purge_dist < occ_ext);
    purge_cnt  = purge_hit ? purge_dist + 12'd1 : 12'd0;
    oldest_new = oldest_seq + purge_cnt;
    occ_d      = occ_q - OW'(purge_cnt) + OW'(state_q == StCalc);
    occ_d_nz   = (occ_d != '0);
    pend_any   = (pending_q | nak_valid_i) & occ_d_nz;
    cur_seq    = out_q[1195:1184];
    cand_seq   = cur_seq + 12'd1;
    last_beat  = (cand_seq == next_seq_q) || !occ_d_nz;
    // An ACK may have freed the next entry; then continue from the new oldest one.
    cand_live  = (cand_seq - oldest_new) < 12'(occ_d);
    rd_idx     = (state_q == StReplay && !pend_any && cand_live) ? AW'(cand_seq)
                                                                 : AW'(oldest_new);
    wr_idx     = AW'(next_seq_q);
    lcrc       = crc32(tlp_q);
    new_word   = {next_seq_q, tlp_q, lcrc};
  end

  assign rd_word = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst && state_q == StCalc) begin
      mem[wr_idx] <= new_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tlp_q       <= '0;
      next_seq_q  <= '0;
      occ_q       <= '0;
      pending_q   <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      pending_q <= pend_any;
      unique case (state_q)
        StIdle: begin
          if (pending_q && occ_d_nz) begin
            state_q     <= StReplay;
            out_q       <= rd_word;
            out_valid_q <= 1'b1;
            pending_q   <= 1'b0;
          end else if (tlp_valid_i && tlp_ready_o) begin
            tlp_q   <= tlp_i;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          out_q       <= new_word;
          out_valid_q <= 1'b1;
          next_seq_q  <= next_seq_q + 12'd1;
          state_q     <= StSend;
        end
        StSend: begin
          if (dll_tlp_ready_i) begin
            if (pend_any) begin
              state_q   <= StReplay;
              out_q     <= rd_word;
              pending_q <= 1'b0;
            end else begin
              state_q     <= StIdle;
              out_valid_q <= 1'b0;
            end
          end
        end
        StReplay: begin
          if (dll_tlp_ready_i) begin
            if (pend_any) begin
              out_q     <= rd_word;
              pending_q <= 1'b0;
            end else if (last_beat) begin
              state_q     <= StIdle;
              out_valid_q <= 1'b0;
            end else begin
              out_q <= rd_word;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tlp_ready_o     = (state_q == StIdle) && (occ_q < OW'(REPLAY_DEPTH)) && !pending_q;
  assign dll_tlp_o       = out_q;
  assign dll_tlp_valid_o = out_valid_q;
  assign next_seq_o      = next_seq_q;
  assign replay_busy_o   = pending_q | (state_q == StReplay);

endmodule
